// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between several requesters.
//                A pending requester is picked round-robin, its word is
//                captured and presented on T_W_o with write_o held high
//                until the UART reports T_locked_i. The arbiter then waits
//                for the UART to go idle before serving the next requester.
//                If the UART never locks within LOCK_TIMEOUT cycles the
//                transfer is dropped and timeout_err_o pulses for one cycle.
//  Ports       :
//    clk            in   system clock, rising edge
//    rst_n          in   asynchronous active-low reset
//    req_i          in   [REQUESTERS]            request level per requester
//    data_i         in   [REQUESTERS*WORD_WIDTH] word of requester i at
//                                                [i*WORD_WIDTH +: WORD_WIDTH]
//    grant_o        out  [REQUESTERS]  one-hot pulse, word captured
//    owner_o        out  [OW]          current / most recent owner index
//    busy_o         out  transfer in progress
//    write_o        out  UART write request
//    T_W_o          out  [WORD_WIDTH]  word presented to the UART
//    T_locked_i     in   UART transmitter busy flag
//    timeout_err_o  out  one-cycle pulse when a transfer is aborted
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int REQUESTERS   = 4,
    parameter int WORD_WIDTH   = 8,
    parameter int LOCK_TIMEOUT = 255,
    localparam int OW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REQUESTERS-1:0]            req_i,
    input  logic [REQUESTERS*WORD_WIDTH-1:0] data_i,
    output logic [REQUESTERS-1:0]            grant_o,
    output logic [OW-1:0]                    owner_o,
    output logic                             busy_o,
    output logic                             write_o,
    output logic [WORD_WIDTH-1:0]            T_W_o,
    input  logic                             T_locked_i,
    output logic                             timeout_err_o
);

    // Timer only has to count up to LOCK_TIMEOUT-1.
    localparam int            TW           = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LIMIT  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [OW-1:0] LAST_RESET   = OW'(REQUESTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_WAIT_FREE = 2'd2
    } state_e;

    state_e                  state_q;
    logic [OW-1:0]           last_q;
    logic [TW-1:0]           timer_q;
    logic [REQUESTERS-1:0]   grant_q;
    logic [OW-1:0]           owner_q;
    logic                    busy_q;
    logic                    write_q;
    logic [WORD_WIDTH-1:0]   tw_q;
    logic                    timeout_err_q;

    logic [OW-1:0]           w_sel;
    logic [OW-1:0]           w_idx;
    logic                    w_found;
    logic [REQUESTERS-1:0]   w_onehot;
    logic [WORD_WIDTH-1:0]   w_word;

    // ------------------------------------------------------------------------
    // Round-robin pick: first set request starting just after the last
    // owner, ascending with wrap. Only used when req_i is non-zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel   = last_q;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            w_idx = OW'((int'(last_q) + i) % REQUESTERS);
            if (!w_found && req_i[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_onehot = REQUESTERS'(1) << w_sel;
        w_word   = data_i[int'(w_sel)*WORD_WIDTH +: WORD_WIDTH];
    end

    // ------------------------------------------------------------------------
    // Arbitration / handshake state machine with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_q        <= LAST_RESET;
            timer_q       <= '0;
            grant_q       <= '0;
            owner_q       <= LAST_RESET;
            busy_q        <= 1'b0;
            write_q       <= 1'b0;
            tw_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // Both strobes are single-cycle pulses.
            grant_q       <= '0;
            timeout_err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A UART locked by someone else blocks new grants.
                    if ((|req_i) && !T_locked_i) begin
                        tw_q    <= w_word;
                        grant_q <= w_onehot;
                        owner_q <= w_sel;
                        last_q  <= w_sel;
                        write_q <= 1'b1;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= ST_WAIT_LOCK;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a simultaneous
                    // timer expiry.
                    if (T_locked_i) begin
                        write_q <= 1'b0;
                        state_q <= ST_WAIT_FREE;
                    end else if (timer_q == TIMER_LIMIT) begin
                        write_q       <= 1'b0;
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                ST_WAIT_FREE: begin
                    if (!T_locked_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign owner_o       = owner_q;
    assign busy_o        = busy_q;
    assign write_o       = write_q;
    assign T_W_o         = tw_q;
    assign timeout_err_o = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. A transaction-level
//                reference predicts the round-robin winner, the captured word
//                and, from the scheduled UART lock delay / busy length, the
//                exact cycle-by-cycle shape of write, busy and timeout_err.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           tl;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic           write;
    logic [W-1:0]   tw;
    logic           terr;

    int             errors;
    int             checks;
    int             last_m;
    int             own_exp;
    logic [W-1:0]   w_exp;

    uart_tx_arbiter #(
        .REQUESTERS  (N),
        .WORD_WIDTH  (W),
        .LOCK_TIMEOUT(L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .data_i       (data),
        .grant_o      (grant),
        .owner_o      (owner),
        .busy_o       (busy),
        .write_o      (write),
        .T_W_o        (tw),
        .T_locked_i   (tl),
        .timeout_err_o(terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: first set request after the previous winner.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // Present r (UART free) for one edge and check the grant it must produce.
    task automatic grant_cycle(input logic [N-1:0] r);
        int sel;
        sel = pick(r, last_m);
        req = r;
        tl  = 1'b0;
        if (sel >= 0) w_exp = data[sel*W +: W];
        step();
        if (sel < 0) begin
            chk("idle_grant", 32'(grant), 0);
            chk("idle_busy",  32'(busy),  0);
            chk("idle_write", 32'(write), 0);
        end else begin
            chk("grant",     32'(grant), 1 << sel);
            chk("owner",     32'(owner), sel);
            chk("tw",        32'(tw),    32'(w_exp));
            chk("write_up",  32'(write), 1);
            chk("busy_up",   32'(busy),  1);
            chk("terr_idle", 32'(terr),  0);
            last_m  = sel;
            own_exp = sel;
        end
    endtask

    // UART locks at the d-th edge after the grant and stays locked for b
    // edges; d > L means it never locks in time. Requester inputs are
    // scrambled meanwhile, which must not disturb the transfer.
    task automatic do_transfer(input int d, input int b);
        bit to;
        int wend;
        int last_k;
        to     = (d > L);
        wend   = to ? L : d;
        last_k = to ? L : d + b;
        for (int k = 1; k <= last_k; k++) begin
            tl   = !to && (k >= d) && (k < d + b);
            req  = N'($urandom);
            data = $urandom;
            step();
            chk("grant_pulse", 32'(grant), 0);
            chk("write",       32'(write), 32'(k < wend));
            chk("busy",        32'(busy),  32'(k < last_k));
            chk("timeout_err", 32'(terr),  32'(to && (k == L)));
            chk("tw_hold",     32'(tw),    32'(w_exp));
            chk("owner_hold",  32'(owner), own_exp);
        end
        tl  = 1'b0;
        req = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = '0;
        data   = '0;
        tl     = 1'b0;
        last_m = N - 1;
        own_exp = N - 1;
        w_exp  = '0;

        // Reset state
        step();
        step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_owner", 32'(owner), N - 1);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_write", 32'(write), 0);
        chk("rst_tw",    32'(tw),    0);
        chk("rst_terr",  32'(terr),  0);
        rst_n = 1'b1;

        // Single transfer, lock after 3 cycles
        data       = $urandom;
        data[7:0]  = 8'hA5;
        grant_cycle(4'b0001);
        do_transfer(3, 2);

        // All requesting, back-to-back round robin, 16 cycles grant to grant
        for (int t = 0; t < 5; t++) begin
            data = $urandom;
            grant_cycle(4'b1111);
            do_transfer(2, 13);
        end

        // Timeout, then fairness continues from the timed-out owner
        data = $urandom;
        grant_cycle(4'b0001);
        do_transfer(L + 2, 1);
        data = $urandom;
        grant_cycle(4'b0011);
        do_transfer(1, 2);

        // UART locked from elsewhere while idle: no grant
        req = 4'b0100;
        tl  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("blocked_grant", 32'(grant), 0);
            chk("blocked_write", 32'(write), 0);
            chk("blocked_busy",  32'(busy),  0);
        end
        data = $urandom;
        grant_cycle(4'b0100);
        do_transfer(2, 2);

        // Asynchronous reset in the middle of WAIT_FREE
        data      = $urandom;
        data[7:0] = 8'h3C;
        grant_cycle(4'b0001);
        chk("tw_3c", 32'(tw), 32'h3C);
        tl = 1'b1;
        step();
        chk("wf_write", 32'(write), 0);
        chk("wf_busy",  32'(busy),  1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_write", 32'(write), 0);
        chk("arst_busy",  32'(busy),  0);
        chk("arst_grant", 32'(grant), 0);
        chk("arst_tw",    32'(tw),    0);
        chk("arst_owner", 32'(owner), N - 1);
        chk("arst_terr",  32'(terr),  0);
        last_m = N - 1;
        req = 4'b0001;
        tl  = 1'b0;
        step();
        step();
        chk("inrst_grant", 32'(grant), 0);
        rst_n = 1'b1;
        data  = $urandom;
        grant_cycle(4'b0001);
        do_transfer(2, 3);

        // Data changed and request dropped after capture
        data        = $urandom;
        data[23:16] = 8'h11;
        grant_cycle(4'b0100);
        data[23:16] = 8'hFF;
        req         = '0;
        do_transfer(3, 2);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                grant_cycle('0);
            end else begin
                data = $urandom;
                grant_cycle(N'($urandom_range(1, 15)));
                do_transfer(int'($urandom_range(1, L + 2)), int'($urandom_range(1, 5)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
